// File: rtl/axi_isolate_ctrl.sv
// axi_isolate_ctrl: drain/reset/reconnect sequencer driving an axi_isolate instance.
// Define AXI_ISOLATE_CTRL_TIMEOUT_EN to bound DRAIN by DrainTimeout cycles.
module axi_isolate_ctrl #(
    parameter int unsigned DrainTimeout  = 1024,
    parameter int unsigned RstHoldCycles = 16,
    parameter int unsigned CntWidth      =
        $clog2(DrainTimeout > RstHoldCycles ? DrainTimeout : RstHoldCycles) + 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       off_req_i,
    input  logic       on_req_i,
    input  logic       isolated_i,
    output logic       isolate_o,
    output logic       dom_rst_o,
    output logic       off_ack_o,
    output logic       busy_o,
    output logic       timeout_o,
    output logic [2:0] state_o
);
    localparam logic [2:0] ACTIVE = 3'd0;
    localparam logic [2:0] DRAIN  = 3'd1;
    localparam logic [2:0] OFF    = 3'd2;
    localparam logic [2:0] WAKE   = 3'd3;
    localparam logic [2:0] RESUME = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d, cnt_inc;
    logic                drain_to;

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

`ifdef AXI_ISOLATE_CTRL_TIMEOUT_EN
    logic timeout_q;
    assign drain_to = (cnt_q == CntWidth'(DrainTimeout - 1)) && !isolated_i;
    always_ff @(posedge clk_i) begin
        if (rst_i)
            timeout_q <= 1'b0;
        else if (state_q == ACTIVE && off_req_i)
            timeout_q <= 1'b0;
        else if (state_q == DRAIN && drain_to)
            timeout_q <= 1'b1;
    end
    assign timeout_o = timeout_q;
`else
    assign drain_to  = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ACTIVE: if (off_req_i) begin
                state_d = DRAIN;
                cnt_d   = '0;
            end
            DRAIN: begin
                cnt_d   = cnt_inc;
                state_d = (isolated_i || drain_to) ? OFF : DRAIN;
            end
            OFF: if (on_req_i) begin
                state_d = WAKE;
                cnt_d   = '0;
            end
            WAKE: begin
                cnt_d   = cnt_inc;
                state_d = (cnt_q == CntWidth'(RstHoldCycles - 1)) ? RESUME : WAKE;
            end
            RESUME:  state_d = isolated_i ? RESUME : ACTIVE;
            default: state_d = ACTIVE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ACTIVE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign isolate_o = state_q == DRAIN || state_q == OFF || state_q == WAKE;
    assign dom_rst_o = state_q == OFF || state_q == WAKE;
    assign off_ack_o = state_q == OFF;
    assign busy_o    = state_q == DRAIN || state_q == WAKE || state_q == RESUME;
    assign state_o   = state_q;
endmodule

// File: tb/tb_axi_isolate_ctrl.sv
// tb_axi_isolate_ctrl: vector table plus directed corner sequences for axi_isolate_ctrl.
module tb_axi_isolate_ctrl;
    // expected pattern: {state[2:0], isolate, dom_rst, off_ack, busy, timeout}
    localparam logic [7:0] E_ACT = 8'b000_00000;
    localparam logic [7:0] E_DRN = 8'b001_10010;
    localparam logic [7:0] E_OFF = 8'b010_11100;
    localparam logic [7:0] E_WAK = 8'b011_11010;
    localparam logic [7:0] E_RES = 8'b100_00010;

    typedef struct {
        logic       rst;
        logic       off;
        logic       on;
        logic       iso;
        logic [7:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1, off_req_i = 1'b0, on_req_i = 1'b0, isolated_i = 1'b0;
    logic       isolate_o, dom_rst_o, off_ack_o, busy_o, timeout_o;
    logic [2:0] state_o;
    logic [7:0] got;
    int         checks = 0;
    int         errors = 0;
    vec_t       tbl[24];

    axi_isolate_ctrl #(.DrainTimeout(8), .RstHoldCycles(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .off_req_i(off_req_i), .on_req_i(on_req_i),
        .isolated_i(isolated_i), .isolate_o(isolate_o), .dom_rst_o(dom_rst_o),
        .off_ack_o(off_ack_o), .busy_o(busy_o), .timeout_o(timeout_o), .state_o(state_o)
    );

    always #5 clk = ~clk;
    assign got = {state_o, isolate_o, dom_rst_o, off_ack_o, busy_o, timeout_o};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", name, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic o, input logic n, input logic i);
        rst_i = r; off_req_i = o; on_req_i = n; isolated_i = i;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(tbl[i].rst, tbl[i].off, tbl[i].on, tbl[i].iso);
            step();
            chk($sformatf("vec%0d", i), tbl[i].exp);
        end
    endtask

    initial begin
        int n;
        int bad;
        tbl[0]  = '{1, 0, 0, 0, E_ACT};
        tbl[1]  = '{1, 1, 1, 1, E_ACT};
        tbl[2]  = '{1, 0, 0, 0, E_ACT};
        tbl[3]  = '{0, 0, 1, 0, E_ACT};
        tbl[4]  = '{0, 1, 1, 0, E_DRN};
        tbl[5]  = '{0, 0, 0, 0, E_DRN};
        tbl[6]  = '{0, 0, 0, 0, E_DRN};
        tbl[7]  = '{0, 0, 0, 0, E_DRN};
        tbl[8]  = '{0, 0, 0, 0, E_DRN};
        tbl[9]  = '{0, 0, 0, 1, E_OFF};
        tbl[10] = '{0, 0, 0, 1, E_OFF};
        tbl[11] = '{0, 1, 1, 1, E_WAK};
        tbl[12] = '{0, 0, 0, 1, E_RES};
        tbl[13] = '{0, 0, 0, 1, E_RES};
        tbl[14] = '{0, 0, 0, 0, E_ACT};
        tbl[15] = '{0, 1, 0, 0, E_DRN};
        tbl[16] = '{1, 1, 0, 0, E_ACT};
        tbl[17] = '{0, 0, 0, 0, E_ACT};
        tbl[18] = '{0, 1, 0, 0, E_DRN};
        tbl[19] = '{0, 0, 0, 1, E_OFF};
        tbl[20] = '{0, 0, 1, 1, E_WAK};
        tbl[21] = '{0, 0, 0, 1, E_WAK};
        tbl[22] = '{1, 0, 0, 1, E_ACT};
        tbl[23] = '{0, 0, 0, 0, E_ACT};

        run_rows(0, 11);
        // WAKE entered on the last edge; count WAKE cycles until RESUME
        drive(0, 0, 0, 1);
        n = 1;
        for (int c = 0; c < 40 && state_o == 3'd3; c++) begin
            step();
            if (state_o == 3'd3) n++;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL wake_len got %0d expected 16", n);
        end
        chk("wake_exit", E_RES);
        run_rows(12, 23);

`ifdef AXI_ISOLATE_CTRL_TIMEOUT_EN
        drive(0, 1, 0, 0);
        step();
        off_req_i = 1'b0;
        n = 1;
        for (int c = 0; c < 30 && state_o == 3'd1; c++) begin
            step();
            if (state_o == 3'd1) n++;
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL drain_len got %0d expected 8", n);
        end
        chk("timeout_off", E_OFF | 8'd1);
        on_req_i = 1'b1;
        step();
        chk("timeout_wake", E_WAK | 8'd1);
        on_req_i = 1'b0;
        for (int c = 0; c < 40 && state_o != 3'd0; c++) step();
        chk("timeout_held", E_ACT | 8'd1);
        off_req_i = 1'b1;
        step();
        chk("timeout_clear", E_DRN);
`else
        drive(0, 1, 0, 0);
        step();
        off_req_i = 1'b0;
        bad = 0;
        repeat (2000) begin
            step();
            if (got !== E_DRN) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL drain_hold got %0d bad cycles expected 0", bad);
        end
        chk("drain_hold_end", E_DRN);
`endif
        drive(1, 0, 0, 0);
        step();
        chk("final_rst", E_ACT);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
